// File: rtl/demux1_2_sched_if.sv
// Handshake bundle between the input word stream, the two output channels and the scheduler.
interface demux1_2_sched_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_dest;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;

    modport master (
        output in_valid, in_data, in_dest, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out1_valid, out1_data
    );

    modport slave (
        input  in_valid, in_data, in_dest, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out1_valid, out1_data
    );
endinterface

// File: rtl/demux1_2_sched.sv
// 1:2 word scheduler: steers each accepted input word into one of two output FIFOs,
// either by per-word destination bit or strict round-robin, with per-channel delivery counters.
module demux1_2_sched #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    demux1_2_sched_if.slave    bus,
    output logic [CNT_W-1:0]   cnt0,
    output logic [CNT_W-1:0]   cnt1,
    output logic               busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_OCC = DEPTH[AW:0];

    logic                  rr_ptr;
    logic                  tgt;
    logic                  accept;
    logic [1:0]            full;
    logic [1:0]            valid;
    logic [1:0]            push;
    logic [1:0]            pop;
    logic [1:0]            out_ready;
    logic [1:0][WIDTH-1:0] head;

    // Ready depends only on the target FIFO's fill level, never on the consumers.
    assign tgt          = mode ? rr_ptr : bus.in_dest;
    assign bus.in_ready = ~full[tgt];
    assign accept       = bus.in_valid & bus.in_ready;
    assign push         = {accept & tgt, accept & ~tgt};
    assign out_ready    = {bus.out1_ready, bus.out0_ready};
    assign pop          = valid & out_ready;

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [WIDTH-1:0] mem [DEPTH];
        logic [AW-1:0]    wr_ptr;
        logic [AW-1:0]    rd_ptr;
        logic [AW:0]      occ;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
            end else begin
                if (push[g]) wr_ptr <= wr_ptr + 1'b1;
                if (pop[g])  rd_ptr <= rd_ptr + 1'b1;
                case ({push[g], pop[g]})
                    2'b10:   occ <= occ + 1'b1;
                    2'b01:   occ <= occ - 1'b1;
                    default: ;
                endcase
            end
        end

        // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
        always_ff @(posedge clk) begin
            if (push[g]) mem[wr_ptr] <= bus.in_data;
        end

        assign valid[g] = (occ != '0);
        assign full[g]  = (occ == FULL_OCC);
        assign head[g]  = valid[g] ? mem[rd_ptr] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
            cnt0   <= '0;
            cnt1   <= '0;
        end else begin
            if (accept && mode) rr_ptr <= ~rr_ptr;
            if (pop[0]) cnt0 <= cnt0 + 1'b1;
            if (pop[1]) cnt1 <= cnt1 + 1'b1;
        end
    end

    assign bus.out0_valid = valid[0];
    assign bus.out0_data  = head[0];
    assign bus.out1_valid = valid[1];
    assign bus.out1_data  = head[1];
    assign busy           = |valid;

endmodule

// File: doc/demux1_2_sched.md
Name: demux1_2_sched

Overview:
- Buffered, flow-controlled scheduler in front of the 1:2 demux datapath.
- Accepts one input word stream (valid/ready) and steers each accepted word to output channel 0 or 1.
- Steering is either by a per-word destination bit or by strict round-robin alternation.
- Each output has its own FIFO and valid/ready handshake, so a stalled consumer never corrupts the other channel; per-channel delivery counters support debug.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 4, entries per output FIFO; power of 2, >= 2.
- CNT_W, 8, width of each delivery counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = destination select (in_dest), 1 = round-robin.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept the input word this cycle.
- in_data  input  WIDTH  input word.
- in_dest  input  1  destination channel; used only when mode = 0.
- out0_valid  output  1  channel 0 head word valid.
- out0_ready  input  1  channel 0 consumer accepts the head word.
- out0_data  output  WIDTH  channel 0 head word.
- out1_valid  output  1  channel 1 head word valid.
- out1_ready  input  1  channel 1 consumer accepts the head word.
- out1_data  output  WIDTH  channel 1 head word.
- cnt0  output  CNT_W  words delivered on channel 0.
- cnt1  output  CNT_W  words delivered on channel 1.
- busy  output  1  high when either FIFO is non-empty.

Behaviour:
- Reset (rst_n low, asynchronous, no clock needed):
  - FIFO read/write pointers and occupancy counts cleared.
  - rr_ptr = 0; cnt0 = cnt1 = 0.
  - out0_valid = out1_valid = 0; out0_data = out1_data = 0; busy = 0.
  - in_ready reflects empty FIFOs, i.e. 1 while in reset.
- Target channel (combinational): tgt = in_dest when mode = 0, tgt = rr_ptr when mode = 1.
- in_ready = NOT full(FIFO[tgt]).
  - in_ready does not depend on in_valid or on the out*_ready inputs: no combinational ready path from output to input.
- Input accept = in_valid & in_ready. On accept, in_data is written into FIFO[tgt].
- Round-robin pointer:
  - rr_ptr toggles on every accept made while mode = 1; it holds otherwise.
  - rr_ptr is not reset on a mode change.
  - Alternation is strict: if FIFO[rr_ptr] is full, input stalls even when the other FIFO has space (head-of-line blocking is intended; preserves alternation order).
- Mode change:
  - mode is sampled every cycle and affects only the current cycle's target.
  - Words already queued are unaffected.
- Output side:
  - outN_valid = FIFO N non-empty.
  - outN_data = FIFO N head word when valid, 0 when empty.
  - Pop on outN_valid & outN_ready.
  - Latency: a word accepted at edge k is visible on outN_valid/outN_data after edge k (one cycle, registered occupancy). No same-cycle pass-through.
- Occupancy per FIFO:
  - push only: +1; pop only: -1; push and pop same cycle: unchanged, pointers both advance.
  - Full = DEPTH entries, so push is impossible while full (in_ready low for that target); a pop at full frees space for the next cycle.
- Pointers are log2(DEPTH) bits and wrap naturally; occupancy counter is log2(DEPTH)+1 bits.
- Counters: cntN increments by 1 on each channel N pop and wraps from 2^CNT_W-1 to 0 with no saturation or flag.
- busy = out0_valid | out1_valid.
- FIFO order is strictly preserved per channel; no reordering, duplication or drop under any ready pattern.
- Reset asserted mid-transfer discards all queued words. The first accept after reset release goes to channel 0 in mode 1.

Test Plan:
- Reset, then mode=0 with words 0x11 (dest 0), 0x22 (dest 1), 0x33 (dest 0), both readies high -> out0 delivers 0x11 then 0x33, out1 delivers 0x22; cnt0 = 2, cnt1 = 1; each word appears one cycle after accept.
- mode=1, stream 0xA0..0xA7, both readies high -> out0 delivers A0, A2, A4, A6 and out1 delivers A1, A3, A5, A7; rr_ptr ends at 0.
- mode=0, DEPTH=4, all words dest 1, out1_ready=0 -> after 4 accepts in_ready=0 and out1 holds words 1-4. Raise out1_ready one cycle -> in_ready=1 next cycle; word 5 accepted in order.
- mode=1, out0_ready=0, out1_ready=1 -> stall after FIFO0 fills (4 words to ch0, 4 to ch1, then in_ready=0 with rr_ptr=0) despite ch1 empty. Release out0_ready -> alternation resumes.
- Simultaneous push/pop on ch0 with occupancy 2 over 10 cycles -> occupancy stays 2, order intact. Preload cnt0 to 255 via 255 pops (CNT_W=8), pop once more -> cnt0 = 0.
- Assert rst_n low asynchronously with 3 words queued on ch1 -> out1_valid=0, out1_data=0, cnt1=0, busy=0 immediately, before the next clock edge.
